// File: rtl/ccip_host_mem_responder.sv
// Host-side CCI-P memory responder: queues c0 reads / c1 writes from an AFU and
// serves them from an on-chip line memory that is zero-filled after reset.
module ccip_host_mem_responder #(
  parameter int DEPTH          = 1024,
  parameter int RD_LATENCY     = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int ALM_FULL_SLACK = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         c0_req_valid,
  input  logic [41:0]  c0_req_addr,
  input  logic [15:0]  c0_req_mdata,
  input  logic         c1_req_valid,
  input  logic [41:0]  c1_req_addr,
  input  logic [511:0] c1_req_data,
  input  logic [15:0]  c1_req_mdata,
  output logic         c0_alm_full,
  output logic         c1_alm_full,
  output logic         c0_rsp_valid,
  output logic [511:0] c0_rsp_data,
  output logic [15:0]  c0_rsp_mdata,
  output logic         c1_rsp_valid,
  output logic [15:0]  c1_rsp_mdata,
  output logic         init_done,
  output logic         err_oob,
  output logic         err_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALM_THR  = CW'(FIFO_DEPTH - ALM_FULL_SLACK);

  typedef enum logic {S_INIT, S_RUN} state_e;
  state_e state_q, state_d;

  logic [AW-1:0] init_idx_q, init_idx_d;
  logic          last_c1_q, last_c1_d;
  logic          c0_alm_q, c0_alm_d, c1_alm_q, c1_alm_d;
  logic          err_oob_q, err_oob_d, err_ovf_q, err_ovf_d;

  logic [511:0]  mem [DEPTH];

  logic [AW-1:0] c0_addr_mem  [FIFO_DEPTH];
  logic [15:0]   c0_mdata_mem [FIFO_DEPTH];
  logic [AW-1:0] c1_addr_mem  [FIFO_DEPTH];
  logic [511:0]  c1_data_mem  [FIFO_DEPTH];
  logic [15:0]   c1_mdata_mem [FIFO_DEPTH];
  logic [FW-1:0] c0_wp_q, c0_wp_d, c0_rp_q, c0_rp_d;
  logic [FW-1:0] c1_wp_q, c1_wp_d, c1_rp_q, c1_rp_d;
  logic [CW-1:0] c0_cnt_q, c0_cnt_d, c1_cnt_q, c1_cnt_d;

  logic          c0_full, c1_full, c0_push, c1_push;
  logic          issue_rd, issue_wr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [511:0]  mem_wdata;

  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [511:0]          rd_data_q  [RD_LATENCY];
  logic [15:0]           rd_mdata_q [RD_LATENCY];
  logic                  ack_vld_q, ack_vld_d;
  logic [15:0]           ack_mdata_q;

  assign c0_full = (c0_cnt_q == FULL_CNT);
  assign c1_full = (c1_cnt_q == FULL_CNT);
  assign c0_push = c0_req_valid && !c0_full;
  assign c1_push = c1_req_valid && !c1_full;

  // Single-port memory: one access per cycle, round-robin when both queues wait
  always_comb begin
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    if (state_q == S_RUN) begin
      if (c0_cnt_q != '0 && c1_cnt_q != '0) begin
        issue_rd = last_c1_q;
        issue_wr = !last_c1_q;
      end else begin
        issue_rd = (c0_cnt_q != '0);
        issue_wr = (c1_cnt_q != '0);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == S_INIT) begin
      init_idx_d = init_idx_q + AW'(1);
      if (init_idx_q == AW'(DEPTH - 1)) state_d = S_RUN;
    end
    last_c1_d = issue_wr ? 1'b1 : (issue_rd ? 1'b0 : last_c1_q);
    mem_we    = (state_q == S_INIT) || issue_wr;
    mem_waddr = (state_q == S_INIT) ? init_idx_q : c1_addr_mem[c1_rp_q];
    mem_wdata = (state_q == S_INIT) ? '0 : c1_data_mem[c1_rp_q];
  end

  always_comb begin
    c0_wp_d  = c0_push  ? c0_wp_q + FW'(1) : c0_wp_q;
    c0_rp_d  = issue_rd ? c0_rp_q + FW'(1) : c0_rp_q;
    c1_wp_d  = c1_push  ? c1_wp_q + FW'(1) : c1_wp_q;
    c1_rp_d  = issue_wr ? c1_rp_q + FW'(1) : c1_rp_q;
    c0_cnt_d = c0_cnt_q + CW'(c0_push) - CW'(issue_rd);
    c1_cnt_d = c1_cnt_q + CW'(c1_push) - CW'(issue_wr);
    c0_alm_d = (state_d == S_INIT) || (c0_cnt_d >= ALM_THR);
    c1_alm_d = (state_d == S_INIT) || (c1_cnt_d >= ALM_THR);
    err_oob_d = err_oob_q
              | (c0_push && ((c0_req_addr >> AW) != '0))
              | (c1_push && ((c1_req_addr >> AW) != '0));
    err_ovf_d = err_ovf_q | (c0_req_valid && c0_full) | (c1_req_valid && c1_full);
    ack_vld_d = issue_wr;
    rd_vld_d    = '0;
    rd_vld_d[0] = issue_rd;
    for (int k = 1; k < RD_LATENCY; k++) rd_vld_d[k] = rd_vld_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
      last_c1_q  <= 1'b1;
      c0_wp_q    <= '0;
      c0_rp_q    <= '0;
      c1_wp_q    <= '0;
      c1_rp_q    <= '0;
      c0_cnt_q   <= '0;
      c1_cnt_q   <= '0;
      c0_alm_q   <= 1'b0;
      c1_alm_q   <= 1'b0;
      err_oob_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      rd_vld_q   <= '0;
      ack_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      last_c1_q  <= last_c1_d;
      c0_wp_q    <= c0_wp_d;
      c0_rp_q    <= c0_rp_d;
      c1_wp_q    <= c1_wp_d;
      c1_rp_q    <= c1_rp_d;
      c0_cnt_q   <= c0_cnt_d;
      c1_cnt_q   <= c1_cnt_d;
      c0_alm_q   <= c0_alm_d;
      c1_alm_q   <= c1_alm_d;
      err_oob_q  <= err_oob_d;
      err_ovf_q  <= err_ovf_d;
      rd_vld_q   <= rd_vld_d;
      ack_vld_q  <= ack_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (c0_push) begin
      c0_addr_mem[c0_wp_q]  <= c0_req_addr[AW-1:0];
      c0_mdata_mem[c0_wp_q] <= c0_req_mdata;
    end
    if (c1_push) begin
      c1_addr_mem[c1_wp_q]  <= c1_req_addr[AW-1:0];
      c1_data_mem[c1_wp_q]  <= c1_req_data;
      c1_mdata_mem[c1_wp_q] <= c1_req_mdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read stage 0 samples the RAM; later stages only delay toward RD_LATENCY
  always_ff @(posedge clk) begin
    if (issue_rd) begin
      rd_data_q[0]  <= mem[c0_addr_mem[c0_rp_q]];
      rd_mdata_q[0] <= c0_mdata_mem[c0_rp_q];
    end
    for (int k = 1; k < RD_LATENCY; k++) begin
      rd_data_q[k]  <= rd_data_q[k-1];
      rd_mdata_q[k] <= rd_mdata_q[k-1];
    end
    if (issue_wr) ack_mdata_q <= c1_mdata_mem[c1_rp_q];
  end

  assign c0_alm_full  = c0_alm_q;
  assign c1_alm_full  = c1_alm_q;
  assign c0_rsp_valid = rd_vld_q[RD_LATENCY-1];
  assign c0_rsp_data  = rd_data_q[RD_LATENCY-1];
  assign c0_rsp_mdata = rd_mdata_q[RD_LATENCY-1];
  assign c1_rsp_valid = ack_vld_q;
  assign c1_rsp_mdata = ack_mdata_q;
  assign init_done    = (state_q == S_RUN);
  assign err_oob      = err_oob_q;
  assign err_ovf      = err_ovf_q;
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Bench for ccip_host_mem_responder: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based transaction model.
module tb_ccip_host_mem_responder;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int FD     = 8;
  localparam int SLACK  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         c0_req_valid = 1'b0;
  logic [41:0]  c0_req_addr = '0;
  logic [15:0]  c0_req_mdata = '0;
  logic         c1_req_valid = 1'b0;
  logic [41:0]  c1_req_addr = '0;
  logic [511:0] c1_req_data = '0;
  logic [15:0]  c1_req_mdata = '0;
  logic         c0_alm_full, c1_alm_full, c0_rsp_valid, c1_rsp_valid;
  logic [511:0] c0_rsp_data;
  logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
  logic         init_done, err_oob, err_ovf;

  ccip_host_mem_responder #(.DEPTH(DEPTH), .RD_LATENCY(RD_LAT), .FIFO_DEPTH(FD),
                            .ALM_FULL_SLACK(SLACK)) dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data),
    .c1_req_mdata(c1_req_mdata),
    .c0_alm_full(c0_alm_full), .c1_alm_full(c1_alm_full),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data), .c0_rsp_mdata(c0_rsp_mdata),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .init_done(init_done), .err_oob(err_oob), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {logic [41:0] addr; logic [511:0] data; logic [15:0] mdata;} req_t;
  typedef struct {int due; logic [511:0] data; logic [15:0] mdata;} rsp_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: request queues, pending responses, backing store
  req_t         rq[$], wq[$];
  rsp_t         c0p[$], c1p[$];
  logic [511:0] m_mem [DEPTH];
  bit           m_init = 1'b1;
  int           m_icnt = 0;
  bit           m_last_c1 = 1'b1;
  bit           m_oob, m_ovf, m_alm0, m_alm1;

  int           o0_cyc[$], o1_cyc[$];
  logic [511:0] o0_data[$];
  logic [15:0]  o0_md[$], o1_md[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_update();
    req_t r;
    rsp_t p;
    bit f0, f1;
    if (reset) begin
      rq.delete(); wq.delete(); c0p.delete(); c1p.delete();
      m_init = 1'b1; m_icnt = 0; m_last_c1 = 1'b1;
      m_oob = 1'b0; m_ovf = 1'b0; m_alm0 = 1'b0; m_alm1 = 1'b0;
      return;
    end
    f0 = (rq.size() == FD);
    f1 = (wq.size() == FD);
    if (!m_init && rq.size() > 0 && (wq.size() == 0 || m_last_c1)) begin
      r = rq.pop_front();
      p.due = cyc + RD_LAT; p.data = m_mem[int'(r.addr % DEPTH)]; p.mdata = r.mdata;
      c0p.push_back(p);
      m_last_c1 = 1'b0;
    end else if (!m_init && wq.size() > 0) begin
      r = wq.pop_front();
      m_mem[int'(r.addr % DEPTH)] = r.data;
      p.due = cyc + 1; p.data = '0; p.mdata = r.mdata;
      c1p.push_back(p);
      m_last_c1 = 1'b1;
    end
    if (m_init) begin
      m_mem[m_icnt] = '0;
      m_icnt++;
      if (m_icnt == DEPTH) m_init = 1'b0;
    end
    if (c0_req_valid) begin
      if (f0) m_ovf = 1'b1;
      else begin
        r.addr = c0_req_addr; r.data = '0; r.mdata = c0_req_mdata;
        rq.push_back(r);
        if (c0_req_addr >= DEPTH) m_oob = 1'b1;
      end
    end
    if (c1_req_valid) begin
      if (f1) m_ovf = 1'b1;
      else begin
        r.addr = c1_req_addr; r.data = c1_req_data; r.mdata = c1_req_mdata;
        wq.push_back(r);
        if (c1_req_addr >= DEPTH) m_oob = 1'b1;
      end
    end
    m_alm0 = m_init || (rq.size() >= FD - SLACK);
    m_alm1 = m_init || (wq.size() >= FD - SLACK);
  endfunction

  task automatic compare();
    rsp_t p;
    bit e0, e1;
    e0 = (c0p.size() > 0) && (c0p[0].due == cyc);
    e1 = (c1p.size() > 0) && (c1p[0].due == cyc);
    check("c0_rsp_valid", c0_rsp_valid, e0);
    if (e0) begin
      p = c0p.pop_front();
      check("c0_rsp_data", c0_rsp_data, p.data);
      check("c0_rsp_mdata", c0_rsp_mdata, p.mdata);
    end
    check("c1_rsp_valid", c1_rsp_valid, e1);
    if (e1) begin
      p = c1p.pop_front();
      check("c1_rsp_mdata", c1_rsp_mdata, p.mdata);
    end
    check("c0_alm_full", c0_alm_full, m_alm0);
    check("c1_alm_full", c1_alm_full, m_alm1);
    check("init_done", init_done, !m_init);
    check("err_oob", err_oob, m_oob);
    check("err_ovf", err_ovf, m_ovf);
    if (c0_rsp_valid === 1'b1) begin
      o0_cyc.push_back(cyc); o0_data.push_back(c0_rsp_data); o0_md.push_back(c0_rsp_mdata);
    end
    if (c1_rsp_valid === 1'b1) begin
      o1_cyc.push_back(cyc); o1_md.push_back(c1_rsp_mdata);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    compare();
  endtask

  task automatic idle();
    c0_req_valid = 1'b0;
    c1_req_valid = 1'b0;
  endtask

  task automatic rd(input logic [41:0] a, input logic [15:0] md);
    c0_req_valid = 1'b1; c0_req_addr = a; c0_req_mdata = md;
  endtask

  task automatic wr(input logic [41:0] a, input logic [511:0] d, input logic [15:0] md);
    c1_req_valid = 1'b1; c1_req_addr = a; c1_req_data = d; c1_req_mdata = md;
  endtask

  task automatic clr_logs();
    o0_cyc.delete(); o0_data.delete(); o0_md.delete(); o1_cyc.delete(); o1_md.delete();
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < DEPTH + 20) begin
      step(); n++;
      if (n == DEPTH / 2) begin
        check({tag, "_alm0_mid"}, c0_alm_full, 1'b1);
        check({tag, "_alm1_mid"}, c1_alm_full, 1'b1);
      end
    end
    check({tag, "_cycles"}, n, DEPTH);
  endtask

  function automatic logic [41:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return 42'(r);
    if (r < 18) return 42'(DEPTH + r);
    return 42'h200_0000_0000 | 42'(r);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [511:0] d, tmp;

    // 1: init sweep length and alm_full behaviour
    do_reset();
    wait_init("t1_init");
    step();
    check("t1_run_alm0", c0_alm_full, 1'b0);
    check("t1_run_alm1", c1_alm_full, 1'b0);

    // 2: write then read back, idle latencies
    clr_logs();
    d = '0; d[15:8] = 8'h03; d[23:16] = 8'h05;
    t0 = cyc; wr(42'h10, d, 16'h00A1); step(); idle(); repeat (5) step();
    check("t2_ack_n", o1_cyc.size(), 1);
    if (o1_cyc.size() > 0) begin
      check("t2_ack_cyc", o1_cyc[0], t0 + 2);
      check("t2_ack_md", o1_md[0], 16'h00A1);
    end
    clr_logs();
    t0 = cyc; rd(42'h10, 16'h00B2); step(); idle(); repeat (6) step();
    check("t2_rd_n", o0_cyc.size(), 1);
    if (o0_cyc.size() > 0) begin
      tmp = o0_data[0];
      check("t2_rd_cyc", o0_cyc[0], t0 + 3);
      check("t2_rd_data", tmp[23:8], 16'h0503);
      check("t2_rd_md", o0_md[0], 16'h00B2);
    end

    // 3: same-cycle read/write of one line with the write channel granted last
    wr(42'h30, 512'h1, 16'h0030); step(); idle(); repeat (4) step();
    clr_logs();
    t0 = cyc; rd(42'h20, 16'h00C1); wr(42'h20, 512'hFF, 16'h00C2); step(); idle(); repeat (6) step();
    check("t3_rd_n", o0_cyc.size(), 1);
    check("t3_ack_n", o1_cyc.size(), 1);
    if (o0_cyc.size() > 0 && o1_cyc.size() > 0) begin
      check("t3_rd_cyc", o0_cyc[0], t0 + 3);
      check("t3_rd_data", o0_data[0], 512'h0);
      check("t3_ack_cyc", o1_cyc[0], t0 + 3);
      check("t3_ack_md", o1_md[0], 16'h00C2);
    end
    clr_logs();
    rd(42'h20, 16'h00C3); step(); idle(); repeat (6) step();
    check("t3_rd2_n", o0_cyc.size(), 1);
    if (o0_cyc.size() > 0) check("t3_rd2_data", o0_data[0], 512'hFF);

    // 4: fill the read FIFO during INIT, overflow by one
    do_reset();
    clr_logs();
    for (int i = 0; i < 7; i++) begin rd(42'(i), 16'(16'h0040 + i)); step(); end
    idle(); step();
    check("t4_alm", c0_alm_full, 1'b1);
    check("t4_ovf0", err_ovf, 1'b0);
    rd(42'd7, 16'h0047); step();
    rd(42'd8, 16'h0048); step();
    idle(); step();
    check("t4_ovf1", err_ovf, 1'b1);
    while (init_done !== 1'b1 && cyc < 100000) step();
    repeat (30) step();
    check("t4_rsp_n", o0_md.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < o0_md.size()) check("t4_rsp_order", o0_md[i], 16'(16'h0040 + i));

    // 5: out-of-range address wraps onto line 0 and latches err_oob
    wr(42'h0, 512'hAB, 16'h0050); step(); idle(); repeat (4) step();
    check("t5_oob0", err_oob, 1'b0);
    clr_logs();
    rd(42'(DEPTH), 16'h0051); step(); idle(); repeat (6) step();
    check("t5_rd_n", o0_cyc.size(), 1);
    if (o0_cyc.size() > 0) check("t5_rd_data", o0_data[0], 512'hAB);
    check("t5_oob1", err_oob, 1'b1);
    repeat (20) step();
    check("t5_oob_sticky", err_oob, 1'b1);

    // 6: reset with reads in flight discards them
    rd(42'd1, 16'h0061); step();
    rd(42'd2, 16'h0062); step();
    rd(42'd3, 16'h0063); step();
    idle(); reset = 1'b1;
    clr_logs();
    step(); step(); reset = 1'b0;
    check("t6_oob_clr", err_oob, 1'b0);
    check("t6_ovf_clr", err_ovf, 1'b0);
    check("t6_init_low", init_done, 1'b0);
    wait_init("t6_init");
    repeat (20) step();
    check("t6_no_rsp", o0_cyc.size(), 0);

    // Random mixed traffic against the model
    for (int i = 0; i < 3000; i++) begin
      c0_req_valid = ($urandom_range(0, 99) < 40);
      c0_req_addr  = rand_addr();
      c0_req_mdata = 16'($urandom());
      c1_req_valid = ($urandom_range(0, 99) < 40);
      c1_req_addr  = rand_addr();
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
      c1_req_data  = d;
      c1_req_mdata = 16'($urandom());
      step();
    end
    idle();
    repeat (40) step();
    check("rand_drained_rd", c0p.size(), 0);
    check("rand_drained_wr", c1p.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/ccip_host_mem_responder.md
Name: ccip_host_mem_responder

Overview:
Host-side end of the CCI-P memory channels: accepts c0 read requests and c1 write requests from an AFU and returns c0 read responses and c1 write acks.
Backed by an on-chip line memory, so AFUs such as the add-two-numbers example run standalone in simulation/bring-up with no FIU.
Sits between the AFU's sTx.c0/c1 request outputs and its sRx.c0/c1 response inputs.

Parameters:
DEPTH, 1024, number of 512-bit lines in backing memory (power of 2).
RD_LATENCY, 2, cycles from read issue to c0 response (>=1).
FIFO_DEPTH, 8, entries per request FIFO (power of 2).
ALM_FULL_SLACK, 2, almost-full asserts when occupancy >= FIFO_DEPTH - ALM_FULL_SLACK.

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
c0_req_valid  in  1  read request strobe
c0_req_addr  in  42  cache-line address
c0_req_mdata  in  16  tag echoed in response
c1_req_valid  in  1  write request strobe (single-beat, sop=1)
c1_req_addr  in  42  cache-line address
c1_req_data  in  512  write line
c1_req_mdata  in  16  tag echoed in ack
c0_alm_full  out  1  read FIFO almost full
c1_alm_full  out  1  write FIFO almost full
c0_rsp_valid  out  1  read response strobe
c0_rsp_data  out  512  read line
c0_rsp_mdata  out  16  echoed tag
c1_rsp_valid  out  1  write ack strobe
c1_rsp_mdata  out  16  echoed tag
init_done  out  1  memory clear complete
err_oob  out  1  sticky: address >= DEPTH seen
err_ovf  out  1  sticky: request arrived with FIFO full

Behaviour:
- Interface: one clock, clk; reset is synchronous, active-high.
- Reset: all valids, alm_fulls, init_done, err_oob, err_ovf = 0; both FIFOs flushed; read pipeline flushed; last_grant = c1. FSM -> INIT.
- Reset mid-operation: queued and in-flight requests are discarded silently. No responses are issued for them.
- FSM INIT:
  - Writes zero to line 0..DEPTH-1, one per cycle (DEPTH cycles).
  - c0_alm_full = c1_alm_full = 1.
  - Requests still arriving are queued, not issued.
  - After the last line: RUN, init_done = 1.
- FSM RUN: stays in RUN until reset.
- Acceptance: a request with valid = 1 is pushed in the same cycle T if its FIFO is not full.
  - If the FIFO is full, the request is dropped and err_ovf is set.
- Almost-full: registered, reflects occupancy at end of the previous cycle (same-cycle push and pop both counted).
- Addressing:
  - Memory index = addr[log2(DEPTH)-1:0]; the access wraps.
  - Any addr >= DEPTH also sets err_oob, sampled at push time.
- Issue: at most one memory access per cycle (single-port RAM), RUN only.
  - Only one FIFO non-empty: issue its head.
  - Both non-empty: alternate, granting the channel not in last_grant; last_grant updates on every issue.
  - A FIFO head pushed at T is issuable at T+1 at the earliest.
- Read: issued at cycle I -> c0_rsp_valid = 1 for exactly one cycle at I+RD_LATENCY, with data and mdata. Responses are in issue order.
- Write: memory updated at issue cycle I -> c1_rsp_valid for one cycle at I+1.
- Ordering: a read issued after a write to the same index returns the new data. This includes a read issued in cycle I+1 after a write issued in I.
- No back-pressure on responses: the AFU must always accept them.
- Idle, RUN: c0 read accepted at T -> response at T+1+RD_LATENCY; c1 write at T -> ack at T+2.

Test Plan:
1. Reset, then count cycles until init_done -> rises exactly DEPTH (1024) cycles after reset deassert. Both alm_full = 1 throughout INIT, 0 after.
2. RUN: write addr 0x10, data[23:8] = {8'h05, 8'h03}, mdata 0x00A1 -> c1_rsp_valid at T+2, mdata 0x00A1. Then read 0x10, mdata 0x00B2 -> c0_rsp at T+3, data[23:8] = 16'h0503, mdata 0x00B2.
3. Same-cycle read 0x20 and write 0x20 = 0xFF with last_grant = c1:
   - Read is granted first and returns 0 (init value).
   - Write ack follows.
   - A second read of 0x20 returns 0xFF.
4. Push 7 reads back-to-back during INIT -> c0_alm_full asserted, err_ovf = 0. Push 2 more -> 8th accepted, 9th dropped, err_ovf = 1, only 8 responses after init, in order.
5. Read addr 1024 (DEPTH) after writing 0xAB to line 0 -> returns 0xAB, err_oob = 1 and remains 1 until reset.
6. Reset asserted while 3 reads are in flight -> no c0_rsp_valid after reset, FIFOs empty, INIT restarts, errors cleared.
